// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight producers, forwards operands and stalls on load-use hazards
module hazard_scoreboard #(
  parameter int XLEN      = 32,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_valid_i,
  input  logic [4:0]                id_rs1_i,
  input  logic [4:0]                id_rs2_i,
  input  logic                      id_use_rs1_i,
  input  logic                      id_use_rs2_i,
  input  logic [4:0]                id_rd_i,
  input  logic                      id_we_i,
  input  logic                      id_is_load_i,
  input  logic                      flush_i,
  input  logic [FWD_DEPTH*XLEN-1:0] stage_data_i,
  output logic                      stall_o,
  output logic                      fwd1_hit_o,
  output logic                      fwd2_hit_o,
  output logic [XLEN-1:0]           fwd1_data_o,
  output logic [XLEN-1:0]           fwd2_data_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);
  logic [FWD_DEPTH-1:0] v, we, ld;
  logic [4:0]           rd [FWD_DEPTH];
  logic                 stall1, stall2, ins;
  assign stall_o = id_valid_i && !flush_i && (stall1 || stall2);
  assign ins     = id_valid_i && !stall_o && !flush_i;
  // scan oldest to youngest so the youngest matching producer overrides older ones
  always_comb begin
    stall1      = 1'b0;
    stall2      = 1'b0;
    fwd1_hit_o  = 1'b0;
    fwd2_hit_o  = 1'b0;
    fwd1_data_o = '0;
    fwd2_data_o = '0;
    for (int k = FWD_DEPTH-1; k >= 0; k--) begin
      if (v[k] && we[k] && rd[k] == id_rs1_i && id_rs1_i != 5'd0 && id_use_rs1_i) begin
        stall1      = ld[k] && k < LOAD_LAT;
        fwd1_hit_o  = !stall1;
        fwd1_data_o = stall1 ? '0 : stage_data_i[k*XLEN +: XLEN];
      end
      if (v[k] && we[k] && rd[k] == id_rs2_i && id_rs2_i != 5'd0 && id_use_rs2_i) begin
        stall2      = ld[k] && k < LOAD_LAT;
        fwd2_hit_o  = !stall2;
        fwd2_data_o = stall2 ? '0 : stage_data_i[k*XLEN +: XLEN];
      end
    end
  end
  // valid bits advance one stage per edge; stall counter saturates
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v           <= '0;
      stall_cnt_o <= '0;
    end else begin
      for (int k = 1; k < FWD_DEPTH; k++) v[k] <= v[k-1];
      v[0]        <= ins;
      stall_cnt_o <= (stall_o && !(&stall_cnt_o)) ? stall_cnt_o + 1'b1 : stall_cnt_o;
    end
  end
  // entry payload follows the valid bits; meaningless while the entry is a bubble
  always_ff @(posedge clk_i) begin
    for (int k = 1; k < FWD_DEPTH; k++) begin
      rd[k] <= rd[k-1];
      we[k] <= we[k-1];
      ld[k] <= ld[k-1];
    end
    rd[0] <= id_rd_i;
    we[0] <= id_we_i;
    ld[0] <= id_is_load_i;
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of forwarding, load-use stalls, flush, x0, saturation and reset
module tb_hazard_scoreboard;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        id_valid_i, id_use_rs1_i, id_use_rs2_i, id_we_i, id_is_load_i, flush_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic [95:0] stage_data;
  logic        stall_o, fwd1_hit_o, fwd2_hit_o;
  logic [31:0] fwd1_data_o, fwd2_data_o;
  logic [1:0]  stall_cnt_o;
  logic        ll_stall, ll_hit1, ll_hit2;
  logic [31:0] ll_data1, ll_data2;
  logic [15:0] ll_cnt;
  int checks = 0;
  int failures = 0;

  hazard_scoreboard #(.XLEN(32), .FWD_DEPTH(3), .LOAD_LAT(1), .CNT_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i), .id_rd_i(id_rd_i), .id_we_i(id_we_i),
    .id_is_load_i(id_is_load_i), .flush_i(flush_i), .stage_data_i(stage_data), .stall_o(stall_o),
    .fwd1_hit_o(fwd1_hit_o), .fwd2_hit_o(fwd2_hit_o), .fwd1_data_o(fwd1_data_o),
    .fwd2_data_o(fwd2_data_o), .stall_cnt_o(stall_cnt_o));

  hazard_scoreboard #(.XLEN(32), .FWD_DEPTH(2), .LOAD_LAT(0), .CNT_W(16)) u_ll0 (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i), .id_rd_i(id_rd_i), .id_we_i(id_we_i),
    .id_is_load_i(id_is_load_i), .flush_i(flush_i), .stage_data_i(stage_data[63:0]), .stall_o(ll_stall),
    .fwd1_hit_o(ll_hit1), .fwd2_hit_o(ll_hit2), .fwd1_data_o(ll_data1),
    .fwd2_data_o(ll_data2), .stall_cnt_o(ll_cnt));

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                       input logic u2, input logic [4:0] d, input logic w, input logic l);
    id_valid_i = v; id_rs1_i = r1; id_rs2_i = r2; id_use_rs1_i = u1; id_use_rs2_i = u2;
    id_rd_i = d; id_we_i = w; id_is_load_i = l;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    flush_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    flush_i = 1'b0;
    stage_data = {3{32'hFFFF_FFFF}};
    drive(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
    tick();
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", stall_o); end
    checks++; if (fwd1_hit_o !== 1'b0 || fwd2_hit_o !== 1'b0) begin failures++; $display("FAIL reset_hits got=%0b%0b exp=00", fwd1_hit_o, fwd2_hit_o); end
    checks++; if (fwd1_data_o !== 32'h0 || fwd2_data_o !== 32'h0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", fwd1_data_o, fwd2_data_o); end
    checks++; if (stall_cnt_o !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt_o); end
    rst_i = 1'b1;
    idle(1);
  endtask

  task automatic test_alu_fwd();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    stage_data = {32'h0, 32'h0, 32'h0000_1234};
    #1;
    checks++; if (fwd1_hit_o !== 1'b1) begin failures++; $display("FAIL alu_hit got=%0b exp=1", fwd1_hit_o); end
    checks++; if (fwd1_data_o !== 32'h0000_1234) begin failures++; $display("FAIL alu_data got=%h exp=00001234", fwd1_data_o); end
    checks++; if (stall_o !== 1'b0 || fwd2_hit_o !== 1'b0) begin failures++; $display("FAIL alu_nostall got=%0b/%0b exp=0/0", stall_o, fwd2_hit_o); end
    id_use_rs1_i = 1'b0;
    #1;
    checks++; if (fwd1_hit_o !== 1'b0 || fwd1_data_o !== 32'h0) begin failures++; $display("FAIL alu_unused got=%0b/%h exp=0/0", fwd1_hit_o, fwd1_data_o); end
    idle(3);
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
    stage_data = {32'h0, 32'hDEAD_BEEF, 32'h0000_5555};
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0b exp=1", stall_o); end
    checks++; if (fwd2_hit_o !== 1'b0) begin failures++; $display("FAIL lu_hit_during_stall got=%0b exp=0", fwd2_hit_o); end
    checks++; if (stall_cnt_o !== 2'd0) begin failures++; $display("FAIL lu_cnt_before got=%0d exp=0", stall_cnt_o); end
    tick();
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL lu_release got=%0b exp=0", stall_o); end
    checks++; if (fwd2_hit_o !== 1'b1 || fwd2_data_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lu_fwd got=%0b/%h exp=1/deadbeef", fwd2_hit_o, fwd2_data_o); end
    checks++; if (stall_cnt_o !== 2'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt_o); end
    tick();
    idle(3);
  endtask

  task automatic test_priority();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd4, 5'd3, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    stage_data = {32'h33, 32'h22, 32'h11};
    #1;
    checks++; if (fwd2_hit_o !== 1'b1 || fwd2_data_o !== 32'h11) begin failures++; $display("FAIL prio_youngest got=%0b/%h exp=1/11", fwd2_hit_o, fwd2_data_o); end
    checks++; if (fwd1_data_o !== 32'h22) begin failures++; $display("FAIL prio_mid got=%h exp=22", fwd1_data_o); end
    tick();
    checks++; if (fwd2_data_o !== 32'h22 || fwd1_data_o !== 32'h33) begin failures++; $display("FAIL prio_shift got=%h/%h exp=22/33", fwd2_data_o, fwd1_data_o); end
    idle(3);
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    flush_i = 1'b1;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL flush_stall got=%0b exp=0", stall_o); end
    tick();
    flush_i = 1'b0;
    checks++; if (stall_cnt_o !== 2'd1) begin failures++; $display("FAIL flush_cnt got=%0d exp=1", stall_cnt_o); end
    drive(1'b1, 5'd10, 5'd7, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0);
    stage_data = {32'h0, 32'hAB, 32'hCD};
    #1;
    checks++; if (fwd1_hit_o !== 1'b0) begin failures++; $display("FAIL flush_bubble got=%0b exp=0", fwd1_hit_o); end
    checks++; if (fwd2_hit_o !== 1'b1 || fwd2_data_o !== 32'hAB || stall_o !== 1'b0) begin failures++; $display("FAIL flush_load_e1 got=%0b/%h/%0b exp=1/ab/0", fwd2_hit_o, fwd2_data_o, stall_o); end
    idle(3);
  endtask

  task automatic test_x0();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
    stage_data = {3{32'hFFFF_FFFF}};
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL x0_stall got=%0b exp=0", stall_o); end
    checks++; if (fwd1_hit_o !== 1'b0 || fwd2_hit_o !== 1'b0 || fwd1_data_o !== 32'h0) begin failures++; $display("FAIL x0_hit got=%0b%0b/%h exp=00/0", fwd1_hit_o, fwd2_hit_o, fwd1_data_o); end
    idle(3);
  endtask

  task automatic test_load_lat0();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    stage_data = {32'h0, 32'h0, 32'h0000_C0DE};
    #1;
    checks++; if (ll_stall !== 1'b0) begin failures++; $display("FAIL ll0_stall got=%0b exp=0", ll_stall); end
    checks++; if (ll_hit1 !== 1'b1 || ll_data1 !== 32'h0000_C0DE) begin failures++; $display("FAIL ll0_fwd got=%0b/%h exp=1/0000c0de", ll_hit1, ll_data1); end
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL ll1_contrast got=%0b exp=1", stall_o); end
    tick();
    idle(3);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL arst_pre_stall got=%0b exp=1", stall_o); end
    #2;
    rst_i = 1'b0;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL arst_stall got=%0b exp=0", stall_o); end
    checks++; if (stall_cnt_o !== 2'd0 || ll_cnt !== 16'd0) begin failures++; $display("FAIL arst_cnt got=%0d/%0d exp=0/0", stall_cnt_o, ll_cnt); end
    checks++; if (fwd1_hit_o !== 1'b0 || fwd1_data_o !== 32'h0) begin failures++; $display("FAIL arst_hit got=%0b/%h exp=0/0", fwd1_hit_o, fwd1_data_o); end
    #1;
    rst_i = 1'b1;
    tick();
    checks++; if (stall_o !== 1'b0 || stall_cnt_o !== 2'd0) begin failures++; $display("FAIL arst_post got=%0b/%0d exp=0/0", stall_o, stall_cnt_o); end
    drive(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    stage_data = {32'h0, 32'h0, 32'h77};
    #1;
    checks++; if (fwd1_hit_o !== 1'b1 || fwd1_data_o !== 32'h77) begin failures++; $display("FAIL arst_insert got=%0b/%h exp=1/77", fwd1_hit_o, fwd1_data_o); end
    idle(3);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
      tick();
      drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL sat_stall%0d got=%0b exp=1", i, stall_o); end
      tick();
      tick();
      if (i == 1) begin
        checks++; if (stall_cnt_o !== 2'd2) begin failures++; $display("FAIL sat_mid got=%0d exp=2", stall_cnt_o); end
      end
    end
    checks++; if (stall_cnt_o !== 2'd3) begin failures++; $display("FAIL sat_final got=%0d exp=3", stall_cnt_o); end
    checks++; if (ll_cnt !== 16'd0) begin failures++; $display("FAIL sat_ll0_cnt got=%0d exp=0", ll_cnt); end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_priority();
    test_flush();
    test_x0();
    test_load_lat0();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
